// File: rtl/pila_param_pkg.sv
// Shared definitions for the pila_param LIFO stack: operation codes and the
// pointer-width helper used to size count/hwm.
package pila_param_pkg;

    // Operation code built as {push, pop}.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpRepl = 2'b11
    } op_e;

    // Pointer width able to hold 0..depth inclusive.
    function automatic int unsigned pw_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pila_param_mem.sv
// Register-array storage for the stack: one synchronous write port and one
// asynchronous read port. Contents are never cleared.
module pila_param_mem
    import pila_param_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next array contents: copy, then overlay the single write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pila_param.sv
// Parametrised LIFO stack with full/empty/count status, overflow/underflow
// pulses and atomic replace-top on simultaneous push and pop.
// Optional feature macro: PILA_HWM_EN enables the high-water-mark register;
// without it the hwm port is tied to zero.
module pila_param
    import pila_param_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW = pw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] salida,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf,
    output logic [PW-1:0]    hwm
);

    localparam int unsigned AW = $clog2(DEPTH);

    op_e              op;
    logic [PW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] rdata;

    assign op      = op_e'({push, pop});
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    // Only meaningful when not empty; the wrap at sp=0 is masked on salida.
    assign top_idx = sp_q[AW-1:0] - AW'(1);

    // Decode the operation into pointer update, memory write and error pulses.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        we    = 1'b0;
        waddr = sp_q[AW-1:0];
        unique case (op)
            OpPush: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + PW'(1);
                end
            end
            OpPop: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    sp_d = sp_q - PW'(1);
                end
            end
            OpRepl: begin
                we = 1'b1;
                if (empty) begin
                    // Nothing to replace: behaves as a plain push.
                    sp_d = sp_q + PW'(1);
                end else begin
                    waddr = top_idx;
                end
            end
            OpNone: begin
            end
        endcase
        // Reset wins over any operation in the same cycle.
        if (reset) begin
            we = 1'b0;
        end
    end

    // Pointer and error-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    pila_param_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(entrada),
        .raddr(top_idx),
        .rdata(rdata)
    );

    assign salida = empty ? '0 : rdata;
    assign count  = sp_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

`ifdef PILA_HWM_EN
    logic [PW-1:0] hwm_q, hwm_d;

    // Track the largest post-edge count; uses sp_d so it moves with count.
    always_comb begin
        hwm_d = hwm_q;
        if (sp_d > hwm_q) begin
            hwm_d = sp_d;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_pila_param.sv
// Self-checking bench for pila_param: a queue-based stack model is compared
// against the DUT every cycle, plus directed sequences with literal values.
module tb_pila_param;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] salida;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;
    logic [PW-1:0]    hwm;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int q[$];
    int exp_ovf = 0;
    int exp_udf = 0;
    int exp_hwm = 0;
    bit model_valid = 1'b0;

    pila_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .entrada(entrada),
        .salida (salida),
        .count  (count),
        .empty  (empty),
        .full   (full),
        .ovf    (ovf),
        .udf    (udf),
        .hwm    (hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exp_top();
        return (q.size() == 0) ? 0 : q[q.size() - 1];
    endfunction

    function automatic int exp_hwm_port();
`ifdef PILA_HWM_EN
        return exp_hwm;
`else
        return 0;
`endif
    endfunction

    // Reference model: stack semantics applied to the inputs seen at each edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                exp_ovf = 0;
                exp_udf = 0;
                exp_hwm = 0;
                model_valid = 1'b1;
            end else begin
                exp_ovf = 0;
                exp_udf = 0;
                if (push && pop) begin
                    if (q.size() == 0) q.push_back(int'(entrada));
                    else q[q.size() - 1] = int'(entrada);
                end else if (push) begin
                    if (q.size() == DEPTH) exp_ovf = 1;
                    else q.push_back(int'(entrada));
                end else if (pop) begin
                    if (q.size() == 0) exp_udf = 1;
                    else void'(q.pop_back());
                end
                if (q.size() > exp_hwm) exp_hwm = q.size();
            end
        end
    end

    // Compare process: every cycle, mid-period, once the model has seen reset.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("count", int'(count), q.size());
                chk("empty", int'(empty), int'(q.size() == 0));
                chk("full", int'(full), int'(q.size() == DEPTH));
                chk("salida", int'(salida), exp_top());
                chk("ovf", int'(ovf), exp_ovf);
                chk("udf", int'(udf), exp_udf);
                chk("hwm", int'(hwm), exp_hwm_port());
            end
        end
    end

    // Apply one cycle of inputs, then settle just after the edge.
    task automatic step(input bit p, input bit o, input int d, input bit r);
        push    = p;
        pop     = o;
        entrada = WIDTH'(d);
        reset   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pct;
        push = 0; pop = 0; entrada = '0; reset = 1;

        // 1. reset then idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t1_count", int'(count), 0);
        chk("t1_empty", int'(empty), 1);
        chk("t1_full", int'(full), 0);
        chk("t1_salida", int'(salida), 0);
        chk("t1_ovf", int'(ovf), 0);
        chk("t1_udf", int'(udf), 0);

        // 2. push 1,2,3 then pop three times
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, i, 0);
            chk("t2_push_salida", int'(salida), i);
        end
        chk("t2_count", int'(count), 3);
        for (int i = 2; i >= 0; i--) begin
            step(0, 1, 0, 0);
            chk("t2_pop_salida", int'(salida), i);
        end
        chk("t2_empty", int'(empty), 1);

        // 3. fill, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 0, 'h10 + i, 0);
        chk("t3_full", int'(full), 1);
        step(1, 0, 'h3FF, 0);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_count", int'(count), 16);
        chk("t3_top", int'(salida), 'h1F);
        step(0, 0, 0, 0);
        chk("t3_ovf_clear", int'(ovf), 0);
        // replace-top when full: no overflow
        step(1, 1, 'h2AA, 0);
        chk("t3_repl_full_ovf", int'(ovf), 0);
        chk("t3_repl_full_top", int'(salida), 'h2AA);

        // 4. underflow, then push&pop on empty
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("t4_udf", int'(udf), 1);
        chk("t4_count", int'(count), 0);
        step(0, 0, 0, 0);
        chk("t4_udf_clear", int'(udf), 0);
        step(1, 1, 'h155, 0);
        chk("t4_count1", int'(count), 1);
        chk("t4_salida", int'(salida), 'h155);
        chk("t4_no_udf", int'(udf), 0);

        // 5. replace-top
        step(0, 0, 0, 1);
        step(1, 0, 'h00A, 0);
        step(1, 0, 'h00B, 0);
        step(1, 1, 'h0FF, 0);
        chk("t5_count", int'(count), 2);
        chk("t5_salida", int'(salida), 'h0FF);
        step(0, 1, 0, 0);
        chk("t5_pop_salida", int'(salida), 'h00A);

        // 6. reset together with push
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 'h40 + i, 0);
        step(1, 0, 'h77, 1);
        chk("t6_count", int'(count), 0);
        chk("t6_salida", int'(salida), 0);
        chk("t6_hwm_reset", int'(hwm), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 'h50 + i, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
`ifdef PILA_HWM_EN
        chk("t6_hwm", int'(hwm), 4);
`else
        chk("t6_hwm_tied", int'(hwm), 0);
`endif

        // Random phase: push bias drifts so both full and empty get exercised.
        for (int n = 0; n < 3000; n++) begin
            pct = ((n / 200) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < pct,
                 $urandom_range(0, 99) < 40,
                 int'($urandom_range(0, 1023)),
                 $urandom_range(0, 199) == 0);
        end

        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
